tpu_host_master: RTL

TPU_HOST_MASTER -- requirements
Module: tpu_host_master

---
 rtl/tpu_host_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tpu_host_master.sv
// Host-side sequencer for the TPU: streams A, B and optionally C into the TPU address map,
// issues MatMul, waits for the array to settle, then reads the C result back out.
module tpu_host_master #(
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_c,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  // valid/ready: a word moves on any rising edge where valid & ready are both high;
  // a producer holds valid and its data stable until that edge.

  localparam int CNT_MAX = (WAIT_CYCLES > 2 * DIM) ? WAIT_CYCLES : 2 * DIM;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

  localparam logic [CW-1:0] LAST_AB   = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_C    = CW'(2 * DIM - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_C, MATMUL, WAIT, READ_C, FINISH
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              load_c_q, load_c_nxt;
  logic              issued, issued_nxt;
  logic              out_valid_nxt;
  logic [DATAW-1:0]  out_data_nxt;
  logic              r_w_nxt;
  logic [ADDRW-1:0]  addr_nxt;
  logic [DATAW-1:0]  wdata_nxt;
  logic              accept;

  function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                 input logic [CW-1:0]    idx);
    return base + (ADDRW'(idx) << 3);
  endfunction

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      load_c_q  <= 1'b0;
      issued    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
    end else begin
      cnt       <= cnt_nxt;
      load_c_q  <= load_c_nxt;
      issued    <= issued_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      tpu_r_w   <= r_w_nxt;
      tpu_addr  <= addr_nxt;
      tpu_wdata <= wdata_nxt;
    end
  end

  // Bus values computed here appear one cycle later from the output registers;
  // every cycle not explicitly driving a transfer falls back to the idle bus.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    load_c_nxt    = load_c_q;
    issued_nxt    = 1'b0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    r_w_nxt       = 1'b0;
    addr_nxt      = '0;
    wdata_nxt     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = LOAD_A;
          load_c_nxt = load_c;
          cnt_nxt    = '0;
        end
      end
      LOAD_A: begin
        if (accept) begin
          r_w_nxt   = 1'b1;
          addr_nxt  = word_addr(A_BASE, cnt);
          wdata_nxt = in_data;
          if (cnt == LAST_AB) begin
            state_nxt = LOAD_B;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          r_w_nxt   = 1'b1;
          addr_nxt  = word_addr(B_BASE, cnt);
          wdata_nxt = in_data;
          if (cnt == LAST_AB) begin
            state_nxt = load_c_q ? LOAD_C : MATMUL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      LOAD_C: begin
        if (accept) begin
          r_w_nxt   = 1'b1;
          addr_nxt  = word_addr(C_BASE, cnt);
          wdata_nxt = in_data;
          if (cnt == LAST_C) begin
            state_nxt = MATMUL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      MATMUL: begin
        r_w_nxt   = 1'b1;
        addr_nxt  = MM_ADDR;
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        // The first WAIT cycle carries the MatMul write, so the count runs one past WAIT_CYCLES.
        if (cnt == LAST_WAIT) begin
          state_nxt  = READ_C;
          cnt_nxt    = '0;
          addr_nxt   = C_BASE;
          issued_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      READ_C: begin
        if (issued) begin
          out_data_nxt  = tpu_rdata;
          out_valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (cnt == LAST_C) begin
            state_nxt = FINISH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt    = cnt + CW'(1);
            addr_nxt   = word_addr(C_BASE, cnt + CW'(1));
            issued_nxt = 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
